// File: rtl/if_stage_mq.sv
// -----------------------------------------------------------------------------
// if_stage_mq -- multi-outstanding instruction fetch stage.
//
// The pre-IF PC generator issues fetches on an SRAM-like instruction port.
// Up to MAX_OUTSTANDING requests may be in flight at once. Returned
// instructions are queued in an IBUF_DEPTH-entry buffer that feeds decode.
// A redirect (branch / exception / eret, muxed upstream) restarts fetch at
// redirect_pc. Responses still in flight at that moment are dropped by a
// cancel counter.
//
// Optional build macro IF_ADEL_EN: a misaligned fetch PC is never issued.
// Instead, one address-error entry (ex=1, excode=5'h04) is queued, and fetch
// halts until the next redirect. Without the macro, misaligned PCs are fetched
// normally and ex/excode are always 0.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   redirect_valid/pc   flush and restart fetch at redirect_pc
//   ds_allowin          decode accepts the buffer head this cycle
//   fs_to_ds_valid      buffer head valid
//   fs_to_ds_bus        {ex[69], excode[68:64], inst[63:32], pc[31:0]}
//   inst_sram_*         SRAM-like fetch port (read-only; in-order data_ok)
// -----------------------------------------------------------------------------
module if_stage_mq #(
   parameter logic [31:0] RESET_PC        = 32'hbfc00000,
   parameter int          IBUF_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [69:0] fs_to_ds_bus,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   // One spare bit in the count width, so that live + ib_cnt cannot overflow.
   localparam int IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
   localparam int CW = $clog2(IBUF_DEPTH + 1) + 1;
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] P_LAST  = PW'(MAX_OUTSTANDING - 1);

   // State
   logic [31:0]   pf_pc;
   logic [69:0]   ibuf [IBUF_DEPTH];
   logic [IW-1:0] ib_rd, ib_wr;
   logic [CW-1:0] ib_cnt;
   logic [31:0]   pend [MAX_OUTSTANDING];
   logic [PW-1:0] pd_rd, pd_wr;
   logic [CW-1:0] outstanding, cancel_cnt;

   // Combinational controls
   logic [CW-1:0] live;             // in-flight requests whose data will be kept
   logic [CW-1:0] outstanding_next;
   logic          fetch_ok;
   logic          adel_write;
   logic          accept, ret_keep, ib_push, ib_pop;
   logic [69:0]   push_data;

   // The pending-PC FIFO depth need not be a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] p_next(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + 1'b1;
   endfunction

   assign live = outstanding - cancel_cnt;

`ifdef IF_ADEL_EN
   logic halted;
   logic misaligned;

   assign misaligned = (pf_pc[1:0] != 2'b00);
   assign fetch_ok   = !misaligned && !halted;
   // Raise the error entry only after every kept response has drained, so
   // that it lands in program order behind them.
   assign adel_write = misaligned && !halted && !redirect_valid &&
                       (ib_cnt < DEPTH_C) && (live == '0);

   always_ff @(posedge clk) begin
      if (reset)               halted <= 1'b0;
      else if (redirect_valid) halted <= 1'b0;
      else if (adel_write)     halted <= 1'b1;
   end
`else
   assign fetch_ok   = 1'b1;
   assign adel_write = 1'b0;
`endif

   // The issue gate counts kept in-flight data against buffer space, so a
   // return can never find the buffer full.
   assign inst_sram_req = !reset && !redirect_valid && fetch_ok &&
                          (outstanding < MAX_C) && ((live + ib_cnt) < DEPTH_C);
   assign accept   = inst_sram_req && inst_sram_addr_ok;
   // A return coinciding with a redirect belongs to the old stream; drop it.
   assign ret_keep = inst_sram_data_ok && (cancel_cnt == '0) && !redirect_valid;
   assign ib_push  = ret_keep || adel_write;
   assign ib_pop   = fs_to_ds_valid && ds_allowin;

   assign push_data = adel_write ? {1'b1, 5'h04, 32'h0, pf_pc}
                                 : {1'b0, 5'h00, inst_sram_rdata, pend[pd_rd]};

   // NOTE: always_comb assigns a default before any branch, so no latch can form.
   always_comb begin
      outstanding_next = outstanding;
      case ({accept, inst_sram_data_ok})
         2'b10:   outstanding_next = outstanding + 1'b1;
         2'b01:   outstanding_next = outstanding - 1'b1;
         default: outstanding_next = outstanding;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pf_pc       <= RESET_PC;
         outstanding <= '0;
         cancel_cnt  <= '0;
         pd_rd       <= '0;
         pd_wr       <= '0;
         ib_rd       <= '0;
         ib_wr       <= '0;
         ib_cnt      <= '0;
         // NOTE: the buffer arrays are small and must read as zero after
         // reset, so they are cleared here instead of left uninitialised.
         for (int i = 0; i < IBUF_DEPTH; i++)      ibuf[i] <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) pend[i] <= '0;
      end else begin
         // Redirect wins over sequential PC advance.
         if (redirect_valid)  pf_pc <= redirect_pc;
         else if (accept)     pf_pc <= pf_pc + 32'd4;

         outstanding <= outstanding_next;

         // Everything still in flight after this cycle belongs to the old stream.
         if (redirect_valid)
            cancel_cnt <= outstanding_next;
         else if (inst_sram_data_ok && (cancel_cnt != '0))
            cancel_cnt <= cancel_cnt - 1'b1;

         if (redirect_valid) begin
            pd_rd <= '0;
            pd_wr <= '0;
         end else begin
            if (accept) begin
               pend[pd_wr] <= pf_pc;
               pd_wr       <= p_next(pd_wr);
            end
            if (ret_keep) pd_rd <= p_next(pd_rd);
         end

         // A pop in the redirect cycle is subsumed by the flush.
         if (redirect_valid) begin
            ib_rd  <= '0;
            ib_wr  <= '0;
            ib_cnt <= '0;
         end else begin
            if (ib_push) begin
               ibuf[ib_wr] <= push_data;
               ib_wr       <= ib_wr + 1'b1;
            end
            if (ib_pop) ib_rd <= ib_rd + 1'b1;
            case ({ib_push, ib_pop})
               2'b10:   ib_cnt <= ib_cnt + 1'b1;
               2'b01:   ib_cnt <= ib_cnt - 1'b1;
               default: ib_cnt <= ib_cnt;
            endcase
         end
      end
   end

   assign fs_to_ds_valid = (ib_cnt != '0);
   assign fs_to_ds_bus   = fs_to_ds_valid ? ibuf[ib_rd] : '0;

   assign inst_sram_addr  = pf_pc;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'd2;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage_mq.sv
// -----------------------------------------------------------------------------
// tb_if_stage_mq -- randomized self-checking bench for if_stage_mq.
//
// A transaction-level model tracks the following:
//   - the expected fetch PC;
//   - the list of accepted requests, each tagged with the redirect epoch in
//     which it was issued;
//   - the queue of entries that decode should see.
// A response is kept only if its epoch is current. The bench acts as the
// instruction SRAM: it returns random data, in order.
// Build with +define+IF_ADEL_EN to cover the address-error feature.
// -----------------------------------------------------------------------------
module tb_if_stage_mq;

   localparam logic [31:0] RESET_PC = 32'hbfc00000;
   localparam int IBUF_DEPTH      = 4;
   localparam int MAX_OUTSTANDING = 2;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [69:0] fs_to_ds_bus;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   if_stage_mq #(
      .RESET_PC(RESET_PC), .IBUF_DEPTH(IBUF_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ds_allowin(ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          ep;
   } fetch_t;

   fetch_t      inflight[$];
   logic [69:0] exp_q[$];
   int          epoch;
   logic [31:0] next_pc;
   bit          halted;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int live_cnt();
      int n = 0;
      foreach (inflight[i]) if (inflight[i].ep == epoch) n++;
      return n;
   endfunction

   function automatic bit pc_fetchable(input logic [31:0] pc);
`ifdef IF_ADEL_EN
      return (pc[1:0] == 2'b00) && !halted;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_clear();
      inflight.delete();
      exp_q.delete();
      epoch++;
      next_pc = RESET_PC;
      halted  = 1'b0;
   endtask

   // Hold reset for n cycles. The SRAM side is reset together with the DUT.
   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      ds_allowin = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      model_clear();
      repeat (n) @(negedge clk);
      check("rst_valid", fs_to_ds_valid, 1'b0);
      check("rst_bus", fs_to_ds_bus, 70'h0);
      check("rst_req", inst_sram_req, 1'b0);
      check("rst_wr", inst_sram_wr, 1'b0);
      check("rst_size", inst_sram_size, 2'd2);
      check("rst_wstrb", inst_sram_wstrb, 4'h0);
      check("rst_wdata", inst_sram_wdata, 32'h0);
      reset = 1'b0;
      #1;
      check("rst_addr", inst_sram_addr, RESET_PC);
      check("rst_req_after", inst_sram_req, 1'b1);
   endtask

   // One clock cycle. Compare the registered outputs, drive inputs, check
   // req, then advance the model by the effects of the coming posedge.
   task automatic cycle(input bit rv, input logic [31:0] rpc,
                        input int p_allow, input int p_aok, input int p_dok);
      bit exp_req, accept, adel, stale;
      int live;
      fetch_t f;

      @(negedge clk);
      check("valid", fs_to_ds_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("bus", fs_to_ds_bus, exp_q[0]);

      redirect_valid    = rv;
      redirect_pc       = rpc;
      ds_allowin        = ($urandom_range(99) < p_allow);
      inst_sram_data_ok = (inflight.size() != 0) && ($urandom_range(99) < p_dok);
      inst_sram_rdata   = inst_sram_data_ok ? inflight[0].data : $urandom;
      inst_sram_addr_ok = ($urandom_range(99) < p_aok);
      #1;

      live    = live_cnt();
      exp_req = !rv && (inflight.size() < MAX_OUTSTANDING) &&
                (live + exp_q.size() < IBUF_DEPTH) && pc_fetchable(next_pc);
      check("req", inst_sram_req, exp_req);
      accept = inst_sram_req && inst_sram_addr_ok;

`ifdef IF_ADEL_EN
      adel = !rv && (next_pc[1:0] != 2'b00) && !halted &&
             (exp_q.size() < IBUF_DEPTH) && (live == 0);
`else
      adel = 1'b0;
`endif

      if (ds_allowin && exp_q.size() != 0) void'(exp_q.pop_front());
      if (inst_sram_data_ok) begin
         f = inflight.pop_front();
         stale = (f.ep != epoch) || rv;
         if (!stale) exp_q.push_back({1'b0, 5'h00, f.data, f.pc});
      end
      if (rv) begin
         exp_q.delete();
         epoch++;
         next_pc = rpc;
         halted  = 1'b0;
      end
      if (accept) begin
         check("addr", inst_sram_addr, next_pc);
         f.pc   = inst_sram_addr;
         f.data = $urandom;
         f.ep   = epoch;
         inflight.push_back(f);
         next_pc = next_pc + 32'd4;
      end
      if (adel) begin
         exp_q.push_back({1'b1, 5'h04, 32'h0, next_pc});
         halted = 1'b1;
      end
      if (exp_q.size() > IBUF_DEPTH) check("ibuf_overflow", exp_q.size(), IBUF_DEPTH);
   endtask

   initial begin
      logic [31:0] r;
      bit seen;

      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      ds_allowin = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata = 32'h0;
      epoch = 0;
      next_pc = RESET_PC;
      halted = 1'b0;

      // Streaming with immediate accept and 1-cycle return.
      do_reset(3);
      repeat (30) cycle(1'b0, 32'h0, 100, 100, 100);

      // Decode stall: the buffer fills, req drops, and nothing is lost on release.
      repeat (20) cycle(1'b0, 32'h0, 0, 100, 100);
      check("stall_req", inst_sram_req, 1'b0);
      check("stall_valid", fs_to_ds_valid, 1'b1);
      repeat (15) cycle(1'b0, 32'h0, 100, 100, 100);

      // Two requests in flight, then a redirect: both returns are discarded.
      do_reset(2);
      repeat (2) cycle(1'b0, 32'h0, 0, 100, 0);
      cycle(1'b1, 32'hbfc00380, 0, 100, 0);
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         cycle(1'b0, 32'h0, 0, 100, 100);
         seen = fs_to_ds_valid;
      end
      check("redir_first_pc", fs_to_ds_bus[31:0], 32'hbfc00380);
      repeat (10) cycle(1'b0, 32'h0, 100, 100, 100);

      // Redirect coinciding with accept and return.
      repeat (3) begin
         cycle(1'b0, 32'h0, 100, 100, 100);
         cycle(1'b1, 32'hbfc01000, 100, 100, 100);
      end
      repeat (8) cycle(1'b0, 32'h0, 100, 100, 100);

      // Back-to-back redirects: the last one wins.
      cycle(1'b1, 32'h80001000, 50, 100, 50);
      cycle(1'b1, 32'h80002000, 50, 100, 50);
      @(posedge clk);
      #1;
      check("dbl_redir_addr", inst_sram_addr, 32'h80002000);
      repeat (10) cycle(1'b0, 32'h0, 100, 100, 100);

      // Random traffic, with occasional mid-run resets.
      for (int k = 0; k < 3000; k++) begin
         if (k % 1000 == 999) do_reset(1);
         r = $urandom;
         r[1:0] = 2'b00;
         cycle(($urandom_range(99) < 5), r, 60, 70, 60);
      end

      // Misaligned redirect target.
      cycle(1'b1, 32'h80000002, 0, 100, 100);
      repeat (10) cycle(1'b0, 32'h0, 0, 100, 100);
`ifdef IF_ADEL_EN
      check("adel_req", inst_sram_req, 1'b0);
      check("adel_entry", fs_to_ds_bus, {1'b1, 5'h04, 32'h0, 32'h80000002});
      cycle(1'b0, 32'h0, 100, 100, 100);
      repeat (5) cycle(1'b0, 32'h0, 100, 100, 100);
      check("adel_single", fs_to_ds_valid, 1'b0);
`else
      repeat (10) cycle(1'b0, 32'h0, 100, 100, 100);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
